// File: rtl/fft_frame_sequencer.sv
// Frame sequencer: sample RAM -> window RAM -> FFT core -> magnitude stream.
// Define FFT_TIMEOUT_EN to enable the FFT_WAIT watchdog and err_timeout.
module fft_frame_sequencer #(
  parameter int N       = 64,
  parameter int HOP     = 32,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int SRC_LEN = 1024,
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W-1:0]    src_addr,
  input  logic [DATA_W-1:0]    src_rdata,
  output logic                 win_we,
  output logic [$clog2(N)-1:0] win_addr,
  output logic [DATA_W-1:0]    win_wdata,
  output logic                 fft_start,
  input  logic                 fft_done,
  output logic [$clog2(N)-1:0] out_addr,
  input  logic [DATA_W-1:0]    out_rdata,
  output logic [DATA_W-1:0]    mag_data,
  output logic                 mag_valid,
  input  logic                 mag_ready,
  output logic                 mag_last,
  output logic [ADDR_W-1:0]    frame_idx,
  output logic                 err_timeout
);
  localparam int NW = $clog2(N);
  localparam int CW = $clog2(N + 1);
  localparam int BW = ADDR_W + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  if (SRC_LEN < N) begin : g_len_chk
    $error("SRC_LEN must be >= N");
  end
  if (HOP < 1 || HOP > N) begin : g_hop_chk
    $error("HOP must be in 1..N");
  end
  if (TIMEOUT < 1) begin : g_to_chk
    $error("TIMEOUT must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FFT_GO, S_FFT_WAIT,
    S_DRAIN, S_NEXT, S_FINISH
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [1:0]          ph_q, ph_d;
  logic [BW-1:0]       base_q, base_d;
  logic [ADDR_W-1:0]   fidx_q, fidx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   src_addr_q, src_addr_d;
  logic                win_we_q, win_we_d;
  logic [NW-1:0]       win_addr_q, win_addr_d;
  logic                fft_start_q, fft_start_d;
  logic [NW-1:0]       out_addr_q, out_addr_d;
  logic [DATA_W-1:0]   mag_data_q, mag_data_d;
  logic                mag_valid_q, mag_valid_d;
  logic                mag_last_q, mag_last_d;
  logic [BW+1:0]       next_end;
`ifdef FFT_TIMEOUT_EN
  logic [TW-1:0]       wd_q, wd_d;
  logic                err_q, err_d;
`endif

  // Widened so the end-of-buffer test never wraps.
  assign next_end = (BW+2)'(base_q) + (BW+2)'(HOP)
                  + (BW+2)'(N);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ph_d        = ph_q;
    base_d      = base_q;
    fidx_d      = fidx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    src_addr_d  = src_addr_q;
    win_we_d    = 1'b0;
    win_addr_d  = win_addr_q;
    fft_start_d = 1'b0;
    out_addr_d  = out_addr_q;
    mag_data_d  = mag_data_q;
    mag_valid_d = mag_valid_q;
    mag_last_d  = mag_last_q;
`ifdef FFT_TIMEOUT_EN
    wd_d        = wd_q;
    err_d       = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD;
          busy_d     = 1'b1;
          cnt_d      = '0;
          src_addr_d = base_q[ADDR_W-1:0];
        end
      end
      S_LOAD: begin
        if (cnt_q == CW'(N)) begin
          state_d     = S_FFT_GO;
          fft_start_d = 1'b1;
          src_addr_d  = '0;
        end else begin
          win_we_d   = 1'b1;
          win_addr_d = cnt_q[NW-1:0];
          cnt_d      = cnt_q + 1'b1;
          src_addr_d = ADDR_W'(base_q + BW'(cnt_q) + BW'(1));
        end
      end
      S_FFT_GO: begin
        state_d = S_FFT_WAIT;
`ifdef FFT_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      S_FFT_WAIT: begin
        if (fft_done) begin
          state_d    = S_DRAIN;
          cnt_d      = '0;
          ph_d       = 2'd0;
          out_addr_d = '0;
        end
`ifdef FFT_TIMEOUT_EN
        else if (wd_q == TW'(TIMEOUT - 1)) begin
          state_d = S_NEXT;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      S_DRAIN: begin
        // Per bin: address, capture, then hold until accepted.
        case (ph_q)
          2'd0: ph_d = 2'd1;
          2'd1: begin
            ph_d        = 2'd2;
            mag_data_d  = out_rdata;
            mag_valid_d = 1'b1;
            mag_last_d  = (cnt_q == CW'(N - 1));
          end
          default: begin
            if (mag_ready) begin
              mag_valid_d = 1'b0;
              mag_last_d  = 1'b0;
              ph_d        = 2'd0;
              if (mag_last_q) begin
                state_d = S_NEXT;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
              out_addr_d = cnt_d[NW-1:0];
            end
          end
        endcase
      end
      S_NEXT: begin
        if (next_end <= (BW+2)'(SRC_LEN)) begin
          state_d    = S_LOAD;
          base_d     = base_q + BW'(HOP);
          fidx_d     = fidx_q + 1'b1;
          cnt_d      = '0;
          src_addr_d = ADDR_W'(base_q + BW'(HOP));
        end else begin
          state_d = S_FINISH;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        base_d  = '0;
        fidx_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ph_q        <= '0;
      base_q      <= '0;
      fidx_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      src_addr_q  <= '0;
      win_we_q    <= 1'b0;
      win_addr_q  <= '0;
      fft_start_q <= 1'b0;
      out_addr_q  <= '0;
      mag_data_q  <= '0;
      mag_valid_q <= 1'b0;
      mag_last_q  <= 1'b0;
`ifdef FFT_TIMEOUT_EN
      wd_q        <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ph_q        <= ph_d;
      base_q      <= base_d;
      fidx_q      <= fidx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      src_addr_q  <= src_addr_d;
      win_we_q    <= win_we_d;
      win_addr_q  <= win_addr_d;
      fft_start_q <= fft_start_d;
      out_addr_q  <= out_addr_d;
      mag_data_q  <= mag_data_d;
      mag_valid_q <= mag_valid_d;
      mag_last_q  <= mag_last_d;
`ifdef FFT_TIMEOUT_EN
      wd_q        <= wd_d;
      err_q       <= err_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign src_addr  = src_addr_q;
  assign win_we    = win_we_q;
  assign win_addr  = win_addr_q;
  assign win_wdata = win_we_q ? src_rdata : '0;
  assign fft_start = fft_start_q;
  assign out_addr  = out_addr_q;
  assign mag_data  = mag_data_q;
  assign mag_valid = mag_valid_q;
  assign mag_last  = mag_last_q;
  assign frame_idx = fidx_q;
`ifdef FFT_TIMEOUT_EN
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Bench for fft_frame_sequencer: RAM/FFT models plus a frame-level
// reference stream built from the sample RAM contents.
module tb_fft_frame_sequencer;
  localparam int N = 64;
  localparam int HOP = 32;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SRC_LEN = 1024;
  localparam int TIMEOUT = 4096;
  localparam int NW = $clog2(N);
  localparam int F = (SRC_LEN - N) / HOP + 1;
  localparam logic [DW-1:0] K = 32'h5A5A_0F0F;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done, win_we, fft_start;
  logic [AW-1:0] src_addr, frame_idx;
  logic [DW-1:0] src_rdata, win_wdata, out_rdata, mag_data;
  logic [NW-1:0] win_addr, out_addr;
  logic fft_done;
  logic mag_valid, mag_last, err_timeout;
  logic mag_ready = 1'b1;

  fft_frame_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done(done),
    .src_addr(src_addr), .src_rdata(src_rdata),
    .win_we(win_we), .win_addr(win_addr),
    .win_wdata(win_wdata),
    .fft_start(fft_start), .fft_done(fft_done),
    .out_addr(out_addr), .out_rdata(out_rdata),
    .mag_data(mag_data), .mag_valid(mag_valid),
    .mag_ready(mag_ready), .mag_last(mag_last),
    .frame_idx(frame_idx),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] src_mem [SRC_LEN];
  logic [DW-1:0] win_mem [N];
  logic [DW-1:0] out_mem [N];
  logic [DW-1:0] snap [N];
  int fft_lat = 20;
  bit rand_lat = 1'b0;
  int fft_cnt;

  // RAMs with 1-cycle read latency and an FFT stand-in
  always @(posedge clk) begin
    src_rdata <= src_mem[src_addr];
    out_rdata <= out_mem[out_addr];
    if (win_we) win_mem[win_addr] <= win_wdata;
    if (rst) begin
      fft_cnt <= 0;
      fft_done <= 1'b0;
    end else begin
      fft_done <= 1'b0;
      if (fft_start)
        fft_cnt <= rand_lat ? int'($urandom_range(1, 40))
                            : fft_lat;
      else if (fft_cnt > 0) begin
        fft_cnt <= fft_cnt - 1;
        if (fft_cnt == 1) begin
          fft_done <= 1'b1;
          for (int j = 0; j < N; j++)
            out_mem[j] <= win_mem[j] ^ K;
        end
      end
    end
  end

  int fst_n = 0, we_n = 0, done_n = 0, dbe = 0;
  int last_n = 0, last_err = 0, stab_err = 0, beat_n = 0;
  bit prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic prev_last;
  logic [DW-1:0] got_q [$];

  always @(negedge clk) begin
    if (rst) begin
      beat_n <= 0;
      prev_stall <= 1'b0;
    end else begin
      if (fft_start) begin
        fst_n <= fst_n + 1;
        if (frame_idx == AW'(2)) snap <= win_mem;
      end
      if (win_we) we_n <= we_n + 1;
      if (done) begin
        done_n <= done_n + 1;
        if (busy) dbe <= dbe + 1;
      end
      if (prev_stall && (!mag_valid || mag_data !== prev_data
                         || mag_last !== prev_last))
        stab_err <= stab_err + 1;
      if (mag_valid && mag_ready) begin
        got_q.push_back(mag_data);
        beat_n <= beat_n + 1;
        if (mag_last) last_n <= last_n + 1;
        if (mag_last !== (beat_n % N == N - 1))
          last_err <= last_err + 1;
      end
      prev_stall <= mag_valid && !mag_ready;
      prev_data <= mag_data;
      prev_last <= mag_last;
    end
  end

  int n_chk = 0, n_pass = 0;

  // Reference: frame f, bin j carries sample f*HOP+j through the FFT.
  function automatic int mism(input int b);
    int m;
    m = 0;
    if (got_q.size() < b + F * N) return F * N;
    for (int f = 0; f < F; f++)
      for (int j = 0; j < N; j++)
        if (got_q[b + f * N + j] !== (src_mem[f * HOP + j] ^ K))
          m++;
    return m;
  endfunction

  task automatic fill_random;
    for (int a = 0; a < SRC_LEN; a++) src_mem[a] = $urandom;
  endtask

  task automatic run(input bit poke, input bit rnd,
                     output bit ok, output logic b1);
    int d0, c;
    d0 = done_n;
    c = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    b1 = busy;
    while (done_n == d0 && c < 40000) begin
      @(posedge clk); #1;
      start = poke && (c % 997 == 500);
      if (rnd) mag_ready = 1'($urandom_range(0, 1));
      c++;
    end
    start = 1'b0;
    mag_ready = 1'b1;
    ok = (done_n != d0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
    n_chk++; if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else n_pass++;
    n_chk++; if (mag_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", mag_valid); else n_pass++;
    n_chk++; if (mag_last !== 1'b0) $display("FAIL rst_last got %b want 0", mag_last); else n_pass++;
    n_chk++; if (frame_idx !== '0) $display("FAIL rst_fidx got %0d want 0", frame_idx); else n_pass++;
    n_chk++; if (win_we !== 1'b0) $display("FAIL rst_we got %b want 0", win_we); else n_pass++;
    n_chk++; if (fft_start !== 1'b0) $display("FAIL rst_fst got %b want 0", fft_start); else n_pass++;
    n_chk++; if (src_addr !== '0) $display("FAIL rst_saddr got %0d want 0", src_addr); else n_pass++;
    n_chk++; if (err_timeout !== 1'b0) $display("FAIL rst_err got %b want 0", err_timeout); else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_full_run;
    int s_fst, s_we, s_last, s_done, s_dbe, b, m, le;
    bit ok;
    logic b1;
    fill_random();
    fft_lat = 20; rand_lat = 1'b0;
    s_fst = fst_n; s_we = we_n; s_last = last_n;
    s_done = done_n; s_dbe = dbe; le = last_err;
    b = got_q.size();
    run(1'b1, 1'b0, ok, b1);
    repeat (30) @(posedge clk);
    @(negedge clk);
    m = mism(b);
    n_chk++; if (!ok) $display("FAIL full_done_seen got 0 want 1"); else n_pass++;
    n_chk++; if (b1 !== 1'b1) $display("FAIL full_busy_after_start got %b want 1", b1); else n_pass++;
    n_chk++; if (fst_n - s_fst != F) $display("FAIL full_fft_starts got %0d want %0d", fst_n - s_fst, F); else n_pass++;
    n_chk++; if (got_q.size() - b != F * N) $display("FAIL full_beats got %0d want %0d", got_q.size() - b, F * N); else n_pass++;
    n_chk++; if (m != 0) $display("FAIL full_stream mismatches got %0d want 0", m); else n_pass++;
    n_chk++; if (last_n - s_last != F) $display("FAIL full_lasts got %0d want %0d", last_n - s_last, F); else n_pass++;
    n_chk++; if (last_err != le) $display("FAIL full_last_pos got %0d want %0d", last_err, le); else n_pass++;
    n_chk++; if (we_n - s_we != F * N) $display("FAIL full_win_writes got %0d want %0d", we_n - s_we, F * N); else n_pass++;
    n_chk++; if (done_n - s_done != 1) $display("FAIL full_done_pulses got %0d want 1", done_n - s_done); else n_pass++;
    n_chk++; if (dbe != s_dbe) $display("FAIL full_busy_at_done got %0d want %0d", dbe, s_dbe); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL full_idle_busy got %b want 0", busy); else n_pass++;
    n_chk++; if (err_timeout !== 1'b0) $display("FAIL full_err got %b want 0", err_timeout); else n_pass++;
  endtask

  task automatic test_window;
    int b, m, w;
    bit ok;
    logic b1;
    for (int a = 0; a < SRC_LEN; a++) src_mem[a] = DW'(a);
    b = got_q.size();
    run(1'b0, 1'b0, ok, b1);
    w = 0;
    for (int k = 0; k < N; k++)
      if (snap[k] !== DW'(2 * HOP + k)) w++;
    m = mism(b);
    n_chk++; if (!ok) $display("FAIL win_done_seen got 0 want 1"); else n_pass++;
    n_chk++; if (w != 0) $display("FAIL win_frame2_ram mismatches got %0d want 0", w); else n_pass++;
    n_chk++;
    if (got_q.size() < b + 3 * N || got_q[b + 2 * N] !== (DW'(2 * HOP) ^ K))
      $display("FAIL win_frame2_beat0 got %0d beats want %h first", got_q.size() - b, DW'(2 * HOP) ^ K);
    else n_pass++;
    n_chk++; if (m != 0) $display("FAIL win_stream mismatches got %0d want 0", m); else n_pass++;
  endtask

  task automatic test_backpressure;
    int b, m, se, le;
    bit ok;
    logic b1;
    fill_random();
    rand_lat = 1'b1;
    se = stab_err; le = last_err;
    b = got_q.size();
    run(1'b0, 1'b1, ok, b1);
    rand_lat = 1'b0;
    m = mism(b);
    n_chk++; if (!ok) $display("FAIL bp_done_seen got 0 want 1"); else n_pass++;
    n_chk++; if (stab_err != se) $display("FAIL bp_stable got %0d want %0d", stab_err, se); else n_pass++;
    n_chk++; if (got_q.size() - b != F * N) $display("FAIL bp_beats got %0d want %0d", got_q.size() - b, F * N); else n_pass++;
    n_chk++; if (m != 0) $display("FAIL bp_stream mismatches got %0d want 0", m); else n_pass++;
    n_chk++; if (last_err != le) $display("FAIL bp_last_pos got %0d want %0d", last_err, le); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int c, b, m;
    bit hit, ok;
    logic b1;
    fill_random();
    fft_lat = 20;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    hit = 1'b0;
    c = 0;
    while (!hit && c < 20000) begin
      @(negedge clk);
      hit = (frame_idx == AW'(5)) && mag_valid;
      c++;
    end
    n_chk++; if (!hit) $display("FAIL mid_reach_frame5 got 0 want 1"); else n_pass++;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (busy !== 1'b0) $display("FAIL mid_busy got %b want 0", busy); else n_pass++;
    n_chk++; if (mag_valid !== 1'b0) $display("FAIL mid_valid got %b want 0", mag_valid); else n_pass++;
    n_chk++; if (frame_idx !== '0) $display("FAIL mid_fidx got %0d want 0", frame_idx); else n_pass++;
    rst = 1'b0;
    b = got_q.size();
    run(1'b0, 1'b0, ok, b1);
    m = mism(b);
    n_chk++; if (!ok) $display("FAIL mid_restart_done got 0 want 1"); else n_pass++;
    n_chk++; if (m != 0) $display("FAIL mid_restart_stream mismatches got %0d want 0", m); else n_pass++;
  endtask

`ifdef FFT_TIMEOUT_EN
  task automatic test_timeout;
    int c, e, g;
    bit mv, seen;
    fft_lat = 0; rand_lat = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    c = 0; seen = 1'b0;
    while (!seen && c < 1000) begin
      @(negedge clk);
      seen = fft_start;
      c++;
    end
    e = -1; g = -1; mv = 1'b0; c = 0;
    while (g < 0 && c < 2 * TIMEOUT + 500) begin
      @(negedge clk);
      c++;
      if (err_timeout && e < 0) e = c;
      if (mag_valid) mv = 1'b1;
      if (fft_start) g = c;
    end
    n_chk++; if (!seen) $display("FAIL to_first_fst got 0 want 1"); else n_pass++;
    n_chk++; if (e != TIMEOUT + 1) $display("FAIL to_err_cycle got %0d want %0d", e, TIMEOUT + 1); else n_pass++;
    n_chk++; if (g != TIMEOUT + N + 3) $display("FAIL to_next_fst got %0d want %0d", g, TIMEOUT + N + 3); else n_pass++;
    n_chk++; if (mv) $display("FAIL to_no_valid got 1 want 0"); else n_pass++;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    n_chk++; if (err_timeout !== 1'b0) $display("FAIL to_err_clear got %b want 0", err_timeout); else n_pass++;
    fft_lat = 20;
  endtask
`endif

  initial begin
    for (int j = 0; j < N; j++) out_mem[j] = '0;
    test_reset();
    test_full_run();
    test_window();
    test_backpressure();
    test_reset_mid();
`ifdef FFT_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
